usb_in_ep_buffer: RTL and testbench

Device-side packet buffer for one USB IN endpoint: the responder to an endpoint client that requests, puts bytes and closes packets. Collects client bytes into packet buffers of up to MAX_PKT bytes, hands closed packets to the serial interface engine (SIE) for transmission, frees them on host ACK and maintains the DATA0/DATA1 toggle. Sits between the USB protocol engine and endpoint clients such as the serial bridge.

---
 rtl/usb_in_ep_if.sv | 37 +++
 rtl/usb_in_ep_buffer.sv | 108 ++++++++++
 tb/tb_usb_in_ep_buffer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_in_ep_if.sv
// Client write port and SIE read port of one USB IN endpoint buffer.
// The client/SIE side uses the master modport; the buffer uses the slave modport.
interface usb_in_ep_if #(
  parameter int MAX_PKT = 32,
  parameter int ADDR_W  = 5
) ();
  logic              in_ep_req;
  logic              in_ep_grant;
  logic              in_ep_data_free;
  logic              in_ep_data_put;
  logic [7:0]        in_ep_data;
  logic              in_ep_data_done;
  logic              in_ep_stall;
  logic              in_ep_acked;
  logic              tx_pkt_ready;
  logic [ADDR_W:0]   tx_pkt_len;
  logic [ADDR_W-1:0] tx_rd_addr;
  logic [7:0]        tx_rd_data;
  logic              tx_pkt_ack;
  logic              tx_toggle_clr;
  logic              tx_data_pid;
  logic              tx_stall;

  modport master (
    output in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
           tx_rd_addr, tx_pkt_ack, tx_toggle_clr,
    input  in_ep_grant, in_ep_data_free, in_ep_acked, tx_pkt_ready, tx_pkt_len,
           tx_rd_data, tx_data_pid, tx_stall
  );

  modport slave (
    input  in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
           tx_rd_addr, tx_pkt_ack, tx_toggle_clr,
    output in_ep_grant, in_ep_data_free, in_ep_acked, tx_pkt_ready, tx_pkt_len,
           tx_rd_data, tx_data_pid, tx_stall
  );
endinterface

// File: rtl/usb_in_ep_buffer.sv
// USB IN endpoint packet buffer: collects client bytes into packets for the SIE and tracks DATA0/1.
// Define USB_IN_EP_PINGPONG_EN for two alternating buffers; otherwise a single buffer is used.
module usb_in_ep_buffer #(
  parameter int MAX_PKT = 32,
  parameter int ADDR_W  = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  usb_in_ep_if.slave bus
);
  localparam logic [1:0] ST_FREE    = 2'd0;
  localparam logic [1:0] ST_FILLING = 2'd1;
  localparam logic [1:0] ST_READY   = 2'd2;

  localparam logic [ADDR_W:0] CNT_MAX  = (ADDR_W+1)'(MAX_PKT);
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(MAX_PKT - 1);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);

`ifdef USB_IN_EP_PINGPONG_EN
  localparam int RAM_AW = ADDR_W + 1;
`else
  localparam int RAM_AW = ADDR_W;
`endif

  logic [7:0]        mem [2**RAM_AW];
  logic [1:0]        st  [2];
  logic [ADDR_W:0]   cnt [2];
  logic              wbuf, rbuf;
  logic              toggle, grant, acked, stall;
  logic [7:0]        rd_data;
  logic              wr_open, data_free, put_acc, close_pkt, ack_acc;
  logic [RAM_AW-1:0] waddr, raddr;

  assign wr_open   = (st[wbuf] != ST_READY);
  assign data_free = grant && wr_open && (cnt[wbuf] < CNT_MAX);
  assign put_acc   = bus.in_ep_data_put && data_free;
  // A byte landing in the last slot closes the packet even without data_done.
  assign close_pkt = (grant && bus.in_ep_data_done && wr_open) ||
                     (put_acc && (cnt[wbuf] == CNT_LAST));
  assign ack_acc   = bus.tx_pkt_ack && (st[rbuf] == ST_READY);

`ifdef USB_IN_EP_PINGPONG_EN
  assign waddr = {wbuf, cnt[wbuf][ADDR_W-1:0]};
  assign raddr = {rbuf, bus.tx_rd_addr};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wbuf <= 1'b0;
      rbuf <= 1'b0;
    end else begin
      if (close_pkt) wbuf <= ~wbuf;
      if (ack_acc)   rbuf <= ~rbuf;
    end
  end
`else
  assign wbuf  = 1'b0;
  assign rbuf  = 1'b0;
  assign waddr = cnt[wbuf][ADDR_W-1:0];
  assign raddr = bus.tx_rd_addr;
`endif

  always_ff @(posedge clk) begin
    if (put_acc) mem[waddr] <= bus.in_ep_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data <= '0;
    else          rd_data <= mem[raddr];
  end

  // Ack and close never target the same buffer: close needs it open, ack needs it READY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        st[i]  <= ST_FREE;
        cnt[i] <= '0;
      end
      toggle <= 1'b0;
      grant  <= 1'b0;
      acked  <= 1'b0;
      stall  <= 1'b0;
    end else begin
      grant <= bus.in_ep_req;
      stall <= bus.in_ep_stall;
      acked <= ack_acc;
      if (put_acc) begin
        cnt[wbuf] <= cnt[wbuf] + CNT_ONE;
        st[wbuf]  <= ST_FILLING;
      end
      if (close_pkt) st[wbuf] <= ST_READY;
      if (ack_acc) begin
        st[rbuf]  <= ST_FREE;
        cnt[rbuf] <= '0;
      end
      if (bus.tx_toggle_clr) toggle <= 1'b0;
      else if (ack_acc)      toggle <= ~toggle;
    end
  end

  assign bus.in_ep_grant     = grant;
  assign bus.in_ep_data_free = data_free;
  assign bus.in_ep_acked     = acked;
  assign bus.tx_pkt_ready    = (st[rbuf] == ST_READY);
  assign bus.tx_pkt_len      = cnt[rbuf];
  assign bus.tx_rd_data      = rd_data;
  assign bus.tx_data_pid     = toggle;
  assign bus.tx_stall        = stall;
endmodule

// File: tb/tb_usb_in_ep_buffer.sv
// Self-checking bench for usb_in_ep_buffer: packet-queue reference model plus directed and random traffic.
// Honours USB_IN_EP_PINGPONG_EN the same way as the design.
module tb_usb_in_ep_buffer;
  localparam int MAX_PKT = 32;
  localparam int ADDR_W  = 5;
`ifdef USB_IN_EP_PINGPONG_EN
  localparam int NBUF = 2;
`else
  localparam int NBUF = 1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  usb_in_ep_if #(.MAX_PKT(MAX_PKT), .ADDR_W(ADDR_W)) bus ();
  usb_in_ep_buffer #(.MAX_PKT(MAX_PKT), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: FIFO of closed packets plus the packet being assembled.
  logic [7:0] rp_data [2][MAX_PKT];
  int         rp_len  [2];
  int         rh, nready;
  logic [7:0] cur_data [MAX_PKT];
  int         cur_len;
  logic       m_grant, m_stall, m_acked, m_toggle, m_rd_vld;
  logic [7:0] m_rd;
  logic       m_avail, m_free, m_ack, m_put, m_close;
  int         m_tail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    nready = 0; rh = 0; cur_len = 0;
    m_grant = 1'b0; m_stall = 1'b0; m_acked = 1'b0; m_toggle = 1'b0;
    m_rd = 8'h00; m_rd_vld = 1'b1;
  endtask

  task automatic model_step();
    m_avail = (nready < NBUF);
    m_free  = m_grant && m_avail && (cur_len < MAX_PKT);
    if (nready > 0 && int'(bus.tx_rd_addr) < rp_len[rh]) begin
      m_rd = rp_data[rh][bus.tx_rd_addr];
      m_rd_vld = 1'b1;
    end else begin
      m_rd_vld = 1'b0;
    end
    m_ack   = bus.tx_pkt_ack && (nready > 0);
    m_put   = bus.in_ep_data_put && m_free;
    m_close = bus.in_ep_data_done && m_grant && m_avail;
    if (m_put) begin
      cur_data[cur_len] = bus.in_ep_data;
      cur_len++;
      if (cur_len == MAX_PKT) m_close = 1'b1;
    end
    if (m_ack) begin
      rh = 1 - rh;
      nready--;
    end
    if (m_close) begin
      m_tail = (rh + nready) % 2;
      rp_data[m_tail] = cur_data;
      rp_len[m_tail]  = cur_len;
      nready++;
      cur_len = 0;
    end
    if (bus.tx_toggle_clr) m_toggle = 1'b0;
    else if (m_ack)        m_toggle = ~m_toggle;
    m_acked = m_ack;
    m_grant = bus.in_ep_req;
    m_stall = bus.in_ep_stall;
  endtask

  task automatic compare();
    chk("grant",     32'(bus.in_ep_grant),     32'(m_grant));
    chk("data_free", 32'(bus.in_ep_data_free),
        32'(m_grant && (nready < NBUF) && (cur_len < MAX_PKT)));
    chk("acked",     32'(bus.in_ep_acked),     32'(m_acked));
    chk("pkt_ready", 32'(bus.tx_pkt_ready),    32'(nready > 0));
    chk("pkt_len",   32'(bus.tx_pkt_len),      32'((nready > 0) ? rp_len[rh] : cur_len));
    chk("data_pid",  32'(bus.tx_data_pid),     32'(m_toggle));
    chk("stall",     32'(bus.tx_stall),        32'(m_stall));
    if (m_rd_vld) chk("rd_data", 32'(bus.tx_rd_data), 32'(m_rd));
  endtask

  initial forever begin
    @(negedge clk);
    if (reset_n) compare();
  end

  task automatic next();
    @(posedge clk);
    if (reset_n) model_step();
    else         model_reset();
    @(negedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b);
    bus.in_ep_data_put = 1'b1;
    bus.in_ep_data = b;
    next();
    bus.in_ep_data_put = 1'b0;
  endtask

  task automatic pulse_done();
    bus.in_ep_data_done = 1'b1;
    next();
    bus.in_ep_data_done = 1'b0;
  endtask

  task automatic pulse_ack(input logic clr);
    bus.tx_pkt_ack = 1'b1;
    bus.tx_toggle_clr = clr;
    next();
    bus.tx_pkt_ack = 1'b0;
    bus.tx_toggle_clr = 1'b0;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_grant"}, 32'(bus.in_ep_grant),     32'd0);
    chk({tag, "_free"},  32'(bus.in_ep_data_free), 32'd0);
    chk({tag, "_acked"}, 32'(bus.in_ep_acked),     32'd0);
    chk({tag, "_ready"}, 32'(bus.tx_pkt_ready),    32'd0);
    chk({tag, "_len"},   32'(bus.tx_pkt_len),      32'd0);
    chk({tag, "_rd"},    32'(bus.tx_rd_data),      32'd0);
    chk({tag, "_pid"},   32'(bus.tx_data_pid),     32'd0);
    chk({tag, "_stall"}, 32'(bus.tx_stall),        32'd0);
  endtask

  initial begin
    bus.in_ep_req = 1'b0; bus.in_ep_data_put = 1'b0; bus.in_ep_data = 8'h00;
    bus.in_ep_data_done = 1'b0; bus.in_ep_stall = 1'b0; bus.tx_rd_addr = '0;
    bus.tx_pkt_ack = 1'b0; bus.tx_toggle_clr = 1'b0;
    model_reset();
    next(); next();
    chk_reset_values("rst");

    reset_n = 1'b1;
    bus.in_ep_req = 1'b1;
    next();
    chk("grant_latency", 32'(bus.in_ep_grant), 32'd1);

    // Basic three-byte packet and read-back.
    put_byte(8'h41); put_byte(8'h42); put_byte(8'h43);
    pulse_done();
    chk("p3_ready", 32'(bus.tx_pkt_ready), 32'd1);
    chk("p3_len",   32'(bus.tx_pkt_len),   32'd3);
    chk("p3_pid",   32'(bus.tx_data_pid),  32'd0);
    for (int a = 0; a < 3; a++) begin
      bus.tx_rd_addr = ADDR_W'(a);
      next();
      chk("p3_rd", 32'(bus.tx_rd_data), 32'h41 + 32'(a));
    end
    pulse_ack(1'b0);
    chk("p3_acked", 32'(bus.in_ep_acked),  32'd1);
    chk("p3_pid1",  32'(bus.tx_data_pid),  32'd1);
    next();
    chk("p3_acked_pulse", 32'(bus.in_ep_acked), 32'd0);

    // Zero-length packet.
    pulse_done();
    chk("zlp_ready", 32'(bus.tx_pkt_ready), 32'd1);
    chk("zlp_len",   32'(bus.tx_pkt_len),   32'd0);
    pulse_ack(1'b0);
    chk("zlp_acked", 32'(bus.in_ep_acked), 32'd1);
    chk("zlp_pid",   32'(bus.tx_data_pid), 32'd0);

    // Full packet closes itself.
    for (int i = 0; i < MAX_PKT; i++) put_byte(8'(i));
    chk("max_ready", 32'(bus.tx_pkt_ready), 32'd1);
    chk("max_len",   32'(bus.tx_pkt_len),   32'(MAX_PKT));
    chk("max_free",  32'(bus.in_ep_data_free), 32'(NBUF == 2));
    pulse_ack(1'b0);

    // Two packets back to back.
    put_byte(8'hA0); put_byte(8'hA1); pulse_done();
    put_byte(8'hB0); put_byte(8'hB1); put_byte(8'hB2); pulse_done();
    chk("both_free", 32'(bus.in_ep_data_free), 32'd0);
    chk("both_len1", 32'(bus.tx_pkt_len), 32'd2);
    pulse_ack(1'b0);
`ifdef USB_IN_EP_PINGPONG_EN
    chk("both_free_after_ack", 32'(bus.in_ep_data_free), 32'd1);
    chk("both_len2", 32'(bus.tx_pkt_len), 32'd3);
    pulse_ack(1'b0);
`else
    chk("single_ready_after_ack", 32'(bus.tx_pkt_ready), 32'd0);
`endif

    // Toggle clear wins over ack; stray ack does nothing.
    put_byte(8'h55); pulse_done();
    pulse_ack(1'b1);
    chk("clr_pid",   32'(bus.tx_data_pid), 32'd0);
    chk("clr_acked", 32'(bus.in_ep_acked), 32'd1);
    pulse_ack(1'b0);
    chk("stray_acked", 32'(bus.in_ep_acked),  32'd0);
    chk("stray_ready", 32'(bus.tx_pkt_ready), 32'd0);
    chk("stray_pid",   32'(bus.tx_data_pid),  32'd0);

    // Reset in the middle of a packet.
    for (int i = 0; i < 5; i++) put_byte(8'h60 + 8'(i));
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_reset_values("midrst");
    next();
    reset_n = 1'b1;
    next();
    put_byte(8'h77); pulse_done();
    bus.tx_rd_addr = '0;
    next();
    chk("post_rst_rd",  32'(bus.tx_rd_data),  32'h77);
    chk("post_rst_len", 32'(bus.tx_pkt_len),  32'd1);
    chk("post_rst_pid", 32'(bus.tx_data_pid), 32'd0);
    pulse_ack(1'b0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      bus.in_ep_req       = ($urandom_range(0, 15) != 0);
      bus.in_ep_data_put  = ($urandom_range(0, 9) < 7);
      bus.in_ep_data      = 8'($urandom);
      bus.in_ep_data_done = ($urandom_range(0, 11) == 0);
      bus.in_ep_stall     = ($urandom_range(0, 19) == 0);
      bus.tx_rd_addr      = ADDR_W'($urandom);
      bus.tx_pkt_ack      = ($urandom_range(0, 4) == 0);
      bus.tx_toggle_clr   = ($urandom_range(0, 29) == 0);
      next();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
